// File: rtl/palette_pixel_out_pkg.sv
// Shared types and constants for the palette pixel output stage.
// Holds the fade FSM states, full-brightness level and channel scaler.
package pixel_out_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FADE_OUT,
      DARK,
      FADE_IN
   } fade_state_t;

   localparam logic [4:0] LEVEL_FULL = 5'd16;
   localparam int PAL_DEPTH_DEFAULT = 23;

   // (c * lvl) >> 4 as an 8x5 product; level 16 is an exact pass-through
   function automatic logic [7:0] scale_ch(
      input logic [7:0] c,
      input logic [4:0] lvl
   );
      logic [12:0] p;
      p = 13'(c) * 13'(lvl);
      return p[11:4];
   endfunction

endpackage

// File: rtl/palette_pixel_out_if.sv
// Palette ROM read port: registered address out, colour back a cycle later.
interface palette_pixel_out_if #(
   parameter int IDX_W = 5
);
   logic [IDX_W-1:0] pal_addr;
   logic [23:0]      pal_data;

   modport master (output pal_addr, input pal_data);
   modport slave  (input pal_addr, output pal_data);
endinterface

// File: rtl/palette_pixel_out_fade_ctrl.sv
// Frame-stepped fade controller: vs edge detect, frame counter, fade FSM.
module fade_ctrl
   import pixel_out_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       vs_in,
   input  logic       fade_out_req,
   input  logic       fade_in_req,
   output logic [4:0] fade_level,
   output logic       fade_busy
);

   localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

   fade_state_t      state_q, state_d;
   logic [4:0]       level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             vs_q, vs_d;
   logic             frame_tick;
   logic             step_tick;

   always_comb begin
      vs_d       = vs_in;
      frame_tick = vs_q & ~vs_in;
      step_tick  = frame_tick && (cnt_q == CNT_LAST);
      cnt_d      = cnt_q;
      if (frame_tick) cnt_d = step_tick ? '0 : cnt_q + 1'b1;
      state_d = state_q;
      level_d = level_q;
      case (state_q)
         IDLE: begin
            if (fade_out_req) begin
               state_d = FADE_OUT;
               cnt_d   = '0;
            end
         end
         FADE_OUT: begin
            // a simultaneous fade_out_req keeps us here, so in_req loses
            if (fade_in_req && !fade_out_req) begin
               state_d = FADE_IN;
               cnt_d   = '0;
            end else if (step_tick) begin
               level_d = level_q - 5'd1;
               if (level_q == 5'd1) begin
                  state_d = DARK;
                  cnt_d   = '0;
               end
            end
         end
         DARK: begin
            if (fade_in_req) begin
               state_d = FADE_IN;
               cnt_d   = '0;
            end
         end
         FADE_IN: begin
            if (fade_out_req) begin
               state_d = FADE_OUT;
               cnt_d   = '0;
            end else if (step_tick) begin
               level_d = level_q + 5'd1;
               if (level_q == LEVEL_FULL - 5'd1) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            level_d = LEVEL_FULL;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         level_q <= LEVEL_FULL;
         cnt_q   <= '0;
         vs_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         vs_q    <= vs_d;
      end
   end

   assign fade_level = level_q;
   assign fade_busy  = (state_q == FADE_OUT) || (state_q == FADE_IN);

endmodule

// File: rtl/palette_pixel_out.sv
// Pixel output stage: index select, palette lookup, fade scaling and
// sync/blank delay, all aligned to a 3-cycle latency.
module palette_pixel_out
   import pixel_out_pkg::*;
#(
   parameter int IDX_W           = 5,
   parameter int PAL_DEPTH       = PAL_DEPTH_DEFAULT,
   parameter int TRANSPARENT_IDX = 0,
   parameter int FRAMES_PER_STEP = 2
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                hs_in,
   input  logic                vs_in,
   input  logic                blank_in,
   input  logic                sprite_hit,
   input  logic [IDX_W-1:0]    sprite_idx,
   input  logic [IDX_W-1:0]    bg_idx,
   input  logic                fade_out_req,
   input  logic                fade_in_req,
   palette_pixel_out_if.master pal,
   output logic [7:0]          VGA_R,
   output logic [7:0]          VGA_G,
   output logic [7:0]          VGA_B,
   output logic                hs_out,
   output logic                vs_out,
   output logic                blank_out,
   output logic                fade_busy,
   output logic [4:0]          fade_level
);

   logic [IDX_W-1:0] sel_idx;
   logic [IDX_W-1:0] addr_q, addr_d;
   // sync bundles are {hs, vs, blank}
   logic [2:0]       sync1_q, sync1_d;
   logic [2:0]       sync2_q, sync2_d;
   logic [2:0]       sync3_q, sync3_d;
   logic [7:0]       r_q, r_d;
   logic [7:0]       g_q, g_d;
   logic [7:0]       b_q, b_d;

   fade_ctrl #(
      .FRAMES_PER_STEP (FRAMES_PER_STEP)
   ) u_fade (
      .Clk          (Clk),
      .Reset        (Reset),
      .vs_in        (vs_in),
      .fade_out_req (fade_out_req),
      .fade_in_req  (fade_in_req),
      .fade_level   (fade_level),
      .fade_busy    (fade_busy)
   );

   always_comb begin
      sel_idx = bg_idx;
      if (sprite_hit && (sprite_idx != IDX_W'(TRANSPARENT_IDX)))
         sel_idx = sprite_idx;
      addr_d = (32'(sel_idx) >= PAL_DEPTH) ? '0 : sel_idx;
      sync1_d = {hs_in, vs_in, blank_in};
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      // pal_data lines up with sync2_q; the ROM supplies the middle stage
      r_d = scale_ch(pal.pal_data[23:16], fade_level);
      g_d = scale_ch(pal.pal_data[15:8], fade_level);
      b_d = scale_ch(pal.pal_data[7:0], fade_level);
      if (sync2_q[0]) begin
         r_d = '0;
         g_d = '0;
         b_d = '0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         addr_q  <= '0;
         sync1_q <= '1;
         sync2_q <= '1;
         sync3_q <= '1;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else begin
         addr_q  <= addr_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         sync3_q <= sync3_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
      end
   end

   assign pal.pal_addr = addr_q;
   assign VGA_R        = r_q;
   assign VGA_G        = g_q;
   assign VGA_B        = b_q;
   assign hs_out       = sync3_q[2];
   assign vs_out       = sync3_q[1];
   assign blank_out    = sync3_q[0];

endmodule

// File: tb/tb_palette_pixel_out.sv
// Directed bench for palette_pixel_out with a scoreboard on the pixel path.
module tb_palette_pixel_out;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       hs_in, vs_in, blank_in, sprite_hit;
   logic [4:0] sprite_idx, bg_idx;
   logic       fade_out_req, fade_in_req;
   logic [7:0] VGA_R, VGA_G, VGA_B;
   logic       hs_out, vs_out, blank_out, fade_busy;
   logic [4:0] fade_level;

   palette_pixel_out_if #(.IDX_W(5)) pif ();

   palette_pixel_out #(
      .IDX_W           (5),
      .PAL_DEPTH       (23),
      .TRANSPARENT_IDX (0),
      .FRAMES_PER_STEP (2)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .hs_in        (hs_in),
      .vs_in        (vs_in),
      .blank_in     (blank_in),
      .sprite_hit   (sprite_hit),
      .sprite_idx   (sprite_idx),
      .bg_idx       (bg_idx),
      .fade_out_req (fade_out_req),
      .fade_in_req  (fade_in_req),
      .pal          (pif),
      .VGA_R        (VGA_R),
      .VGA_G        (VGA_G),
      .VGA_B        (VGA_B),
      .hs_out       (hs_out),
      .vs_out       (vs_out),
      .blank_out    (blank_out),
      .fade_busy    (fade_busy),
      .fade_level   (fade_level)
   );

   always #5 Clk = ~Clk;

   logic [23:0] rom [0:31];

   always @(posedge Clk) pif.pal_data <= rom[pif.pal_addr];

   typedef struct packed {
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
      logic        hs;
      logic        vs;
      logic        bl;
      logic [31:0] st;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int m_lvl = 16;

   function automatic logic [7:0] mscale(input logic [7:0] c, input int l,
                                         input logic bl);
      if (bl) return 8'h00;
      return 8'((int'(c) * l) / 16);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic px(input logic sh, input logic [4:0] si,
                     input logic [4:0] bi, input logic bl);
      sprite_hit = sh;
      sprite_idx = si;
      bg_idx     = bi;
      blank_in   = bl;
   endtask

   task automatic step();
      logic [4:0]  idx;
      logic [23:0] c;
      exp_t        e;
      idx = (sprite_hit && sprite_idx != 5'd0) ? sprite_idx : bg_idx;
      if (idx >= 5'd23) idx = 5'd0;
      c    = rom[idx];
      e.r  = mscale(c[23:16], m_lvl, blank_in);
      e.g  = mscale(c[15:8], m_lvl, blank_in);
      e.b  = mscale(c[7:0], m_lvl, blank_in);
      e.hs = hs_in;
      e.vs = vs_in;
      e.bl = blank_in;
      e.st = 32'(cyc);
      q.push_back(e);
      @(posedge Clk);
      #1;
      cyc++;
      chk("pal_addr", 32'(pif.pal_addr), 32'(idx));
      if (q.size() > 0 && q[0].st + 3 == 32'(cyc)) begin
         e = q.pop_front();
         chk("vga_r", 32'(VGA_R), 32'(e.r));
         chk("vga_g", 32'(VGA_G), 32'(e.g));
         chk("vga_b", 32'(VGA_B), 32'(e.b));
         chk("hs_out", 32'(hs_out), 32'(e.hs));
         chk("vs_out", 32'(vs_out), 32'(e.vs));
         chk("blank_out", 32'(blank_out), 32'(e.bl));
      end
   endtask

   task automatic vs_edge();
      vs_in = 1'b0;
      step();
      vs_in = 1'b1;
      step();
   endtask

   task automatic edges(input int n, input int start, input int dir);
      for (int k = 1; k <= n; k++) begin
         vs_edge();
         m_lvl = start + dir * (k / 2);
         chk("fade_level", 32'(fade_level), 32'(m_lvl));
      end
   endtask

   task automatic pulse(input logic fo, input logic fi);
      fade_out_req = fo;
      fade_in_req  = fi;
      step();
      fade_out_req = 1'b0;
      fade_in_req  = 1'b0;
   endtask

   task automatic vis(input int n, input logic [4:0] idx);
      px(1'b0, 5'd0, idx, 1'b0);
      repeat (n) step();
      blank_in = 1'b1;
      repeat (3) step();
   endtask

   initial begin
      for (int i = 0; i < 32; i++)
         rom[i] = {8'(i * 37), 8'(i * 11 + 3), 8'(255 - i * 9)};
      rom[3] = 24'h80FF10;
      rom[7] = 24'hFFFFFF;
      hs_in = 1'b1;
      vs_in = 1'b1;
      fade_out_req = 1'b0;
      fade_in_req  = 1'b0;
      px(1'b0, 5'd0, 5'd0, 1'b1);

      #12;
      chk("rst_pal_addr", 32'(pif.pal_addr), 32'd0);
      chk("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
      chk("rst_syncs", {29'd0, hs_out, vs_out, blank_out}, 32'd7);
      chk("rst_level", 32'(fade_level), 32'd16);
      chk("rst_busy", 32'(fade_busy), 32'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;

      px(1'b1, 5'd3, 5'd9, 1'b0);  step();
      px(1'b1, 5'd0, 5'd5, 1'b0);  step();
      px(1'b0, 5'd3, 5'd25, 1'b0); step();
      px(1'b0, 5'd0, 5'd22, 1'b0); step();
      px(1'b1, 5'd23, 5'd4, 1'b0); step();
      px(1'b1, 5'd3, 5'd0, 1'b1);  step();
      for (int i = 0; i < 6; i++) begin
         hs_in = i[0];
         vs_in = i[1];
         px(1'b0, 5'd7, 5'd7, (i < 3) ? 1'b1 : 1'b0);
         step();
      end
      hs_in = 1'b1;
      vs_in = 1'b1;
      px(1'b0, 5'd3, 5'd3, 1'b0);
      repeat (3) step();
      blank_in = 1'b1;

      pulse(1'b1, 1'b0);
      chk("out_busy", 32'(fade_busy), 32'd1);
      chk("out_level0", 32'(fade_level), 32'd16);
      edges(16, 16, -1);
      chk("mid_busy", 32'(fade_busy), 32'd1);
      vis(4, 5'd7);
      edges(16, 8, -1);
      chk("dark_busy", 32'(fade_busy), 32'd0);

      pulse(1'b0, 1'b1);
      chk("in_busy", 32'(fade_busy), 32'd1);
      edges(32, 0, 1);
      chk("idle_busy", 32'(fade_busy), 32'd0);

      pulse(1'b1, 1'b0);
      edges(12, 16, -1);
      pulse(1'b1, 1'b1);
      chk("both_busy", 32'(fade_busy), 32'd1);
      edges(2, 10, -1);
      pulse(1'b0, 1'b1);
      edges(14, 9, 1);
      chk("back_idle_busy", 32'(fade_busy), 32'd0);

      pulse(1'b1, 1'b0);
      edges(22, 16, -1);
      px(1'b0, 5'd0, 5'd3, 1'b0);
      repeat (7) step();
      chk("lvl5_g", 32'(VGA_G), 32'h4F);
      #2;
      Reset = 1'b1;
      #1;
      chk("arst_level", 32'(fade_level), 32'd16);
      chk("arst_busy", 32'(fade_busy), 32'd0);
      chk("arst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
      chk("arst_hs", 32'(hs_out), 32'd1);
      chk("arst_vs", 32'(vs_out), 32'd1);
      q.delete();
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      repeat (2) @(posedge Clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/palette_pixel_out.md
# palette_pixel_out

Output stage of the pixel pipeline, directly downstream of the sprite/background index generators and wrapped around the 23-entry palette ROM. Each cycle it:
- picks the winning 5-bit colour index (sprite over background, with transparency),
- drives the palette read address and takes back the 24-bit colour one cycle later,
- applies a frame-stepped fade-to-black / fade-from-black effect,
- emits registered 8-bit R/G/B with delayed VGA sync and blank signals, so the pixel data lines up with the syncs.

## Interface
Parameters:
- IDX_W, 5, palette index width
- PAL_DEPTH, 23, valid palette entries (0..PAL_DEPTH-1)
- TRANSPARENT_IDX, 0, sprite index treated as see-through
- FRAMES_PER_STEP, 2, frames per fade level step (≥1)

Ports:
- Clk, in, 1, pixel clock
- Reset, in, 1, asynchronous, active-high
- hs_in, vs_in, in, 1 each, VGA syncs, active-low
- blank_in, in, 1, high outside the visible area
- sprite_hit, in, 1, a sprite covers the current pixel
- sprite_idx, bg_idx, in, IDX_W each, colour indices
- fade_out_req, fade_in_req, in, 1 each, single-cycle command pulses
- pal_addr, out, IDX_W, palette read address (registered)
- pal_data, in, 24, palette colour {R,G,B}; valid exactly 1 cycle after pal_addr
- VGA_R, VGA_G, VGA_B, out, 8 each, pixel colour
- hs_out, vs_out, blank_out, out, 1 each, syncs/blank delayed to match the colour
- fade_busy, out, 1, high in FADE_OUT or FADE_IN
- fade_level, out, 5, current brightness 0..16

## Operation
Index select (stage 1, registered into pal_addr):
- Use sprite_idx if sprite_hit=1 and sprite_idx≠TRANSPARENT_IDX; otherwise use bg_idx.
- Any selected index ≥PAL_DEPTH becomes 0.

Palette return (stage 2): pal_data is registered together with the delayed blank and sync bits.

Scale (stage 3):
- Each channel out = (c × fade_level) >> 4, computed as 8×5 → 13 bits, keeping bits [11:4].
- Level 16 passes the colour through exactly. Level 0 gives black.
- If the delayed blank is 1, RGB is forced to 0.

Frame tick: falling edge of vs_in, detected with one register. A step tick is a frame tick on which the frame counter equals FRAMES_PER_STEP-1. The counter then wraps to 0; on any other frame tick it increments.

Fade FSM states (fade_state_t), with level changes applied on step ticks only:
- IDLE, level 16: fade_out_req → FADE_OUT.
- FADE_OUT: level decrements by 1 per step tick. Reaching 0 → DARK. fade_in_req → FADE_IN, and level resumes from its current value.
- DARK, level 0: fade_in_req → FADE_IN.
- FADE_IN: level increments by 1 per step tick. Reaching 16 → IDLE. fade_out_req → FADE_OUT.
- If both requests arrive in the same cycle, fade_out_req wins.
- A request that does not apply in the current state is ignored (e.g. fade_in_req in IDLE, fade_out_req in DARK).
- The frame counter clears to 0 on every accepted state transition. The first step therefore comes FRAMES_PER_STEP frame ticks later.
- Level never leaves the range 0..16.

## Timing
- Latency from sprite/bg/sync/blank inputs to VGA_R/G/B, hs_out, vs_out and blank_out is 3 cycles for all of them. One cycle of that is inside the palette ROM.
- pal_addr is 1 cycle after its inputs.
- A new fade_level takes effect at stage 3 from the cycle after the step tick. It may change in the middle of a pixel stream and the output need not be frame-aligned.
- Reset values (asynchronous): pal_addr 0; VGA_R/G/B 0; hs_out, vs_out and blank_out 1; every internal sync/blank delay register 1, and the vs edge register 1; state IDLE, fade_level 16, fade_busy 0, frame counter 0.
- Reset during a fade returns immediately to IDLE at full brightness.

## Structure
- Package pixel_out_pkg holds:
  - the fade_state_t enum {IDLE, FADE_OUT, DARK, FADE_IN},
  - LEVEL_FULL = 5'd16,
  - the default PAL_DEPTH.
- Sub-module fade_ctrl contains the vs edge detector, frame counter and FSM. It outputs fade_level and fade_busy.
- The top level holds the index mux, the 3-stage delay line and the scaler.
- The palette ROM is instantiated by the parent, not inside this block.

## Test plan
- Bench palette entry 3 = 24'h80FF10. Drive sprite_hit=1, sprite_idx=3, blank_in=0. Expect pal_addr=3 after 1 cycle and RGB = 80/FF/10 after 3 cycles.
- sprite_hit=1, sprite_idx=0, bg_idx=5 → pal_addr=5. Separately, bg_idx=25 with no sprite → pal_addr=0.
- Same pixel stream with blank_in=1 → RGB=0 3 cycles later. Toggle hs_in/vs_in → hs_out/vs_out repeat the pattern 3 cycles later.
- FRAMES_PER_STEP=2, pulse fade_out_req, feed 32 vs falling edges:
  - fade_level goes 16→15 after the 2nd edge, then steps down, reaching 0 and DARK after the 32nd.
  - fade_busy=1 throughout and 0 in DARK.
  - With level 8, colour FF is output as 7F.
- In FADE_OUT at level 10, assert fade_out_req and fade_in_req together → stays FADE_OUT. Then fade_in_req alone → FADE_IN; level climbs to 16, then IDLE.
- Assert Reset mid-fade at level 5 → fade_level=16, fade_busy=0, RGB=0, hs_out/vs_out=1 immediately, without waiting for a clock edge.
